// File: rtl/alu_selftest_engine.sv
// alu_selftest_engine: built-in self-test initiator that sweeps every operand pair and op through an add/sub ALU and checks it against a golden model
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, mode              sweep start pulse; op select (00 add, 01 sub, 1x add then sub)
//   alu_sub_add, alu_a/b     operation and operands driven to the ALU under test
//   alu_result/carry/zero/overflow  ALU outputs sampled in CHECK
//   busy, done, pass         sweep in progress, completion pulse, no-error verdict
//   err_count                mismatching vectors, saturating
//   fail_vec, fail_got       first failing {op,a,b} and observed {carry,zero,overflow,result}
module alu_selftest_engine #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  output logic               alu_sub_add,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH:0]   fail_vec,
  output logic [WIDTH+2:0]   fail_got
);
  localparam int MSB = WIDTH - 1;
  localparam logic [3:0] SET = 4'(SETTLE);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE_WAIT, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, b, nb;
  logic op, both;
  logic [3:0] cnt;
  logic [WIDTH:0] sum;
  logic exp_v, mism, a_last, b_last;
  logic [WIDTH+2:0] exp_got, got;
  // Golden model: subtraction is a + two's complement of b, so b==0 gives carry 0.
  always_comb begin
    nb = op ? (~b + 1'b1) : b;
    sum = {1'b0, a} + {1'b0, nb};
    exp_v = op ? ((a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]))
               : ((a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]));
    exp_got = {sum[WIDTH], sum[WIDTH-1:0] == '0, exp_v, sum[WIDTH-1:0]};
    got = {alu_carry, alu_zero, alu_overflow, alu_result};
    mism = got != exp_got;
    a_last = &a;
    b_last = &b;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = start ? DRIVE : IDLE;
      DRIVE:       state_nx = SETTLE_WAIT;
      SETTLE_WAIT: state_nx = (cnt <= 4'd1) ? CHECK : SETTLE_WAIT;
      CHECK:       state_nx = (a_last && b_last && !(both && !op)) ? DONE : DRIVE;
      default:     state_nx = IDLE;
    endcase
  end
  assign busy = (state == DRIVE) || (state == SETTLE_WAIT) || (state == CHECK);
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      op <= 1'b0;
      both <= 1'b0;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sub_add <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_vec <= '0;
      fail_got <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= '0;
          b <= '0;
          op <= mode == 2'b01;
          both <= mode[1];
          pass <= 1'b0;
          err_count <= '0;
          fail_vec <= '0;
          fail_got <= '0;
        end
        DRIVE: begin
          alu_a <= a;
          alu_b <= b;
          alu_sub_add <= op;
          cnt <= SET;
        end
        SETTLE_WAIT: cnt <= cnt - 4'd1;
        CHECK: begin
          if (mism) begin
            if (err_count == '0) begin
              fail_vec <= {op, a, b};
              fail_got <= got;
            end
            if (!(&err_count)) err_count <= err_count + 1'b1;
          end
          b <= b + 1'b1;
          if (b_last) a <= a + 1'b1;
          // Full operand wrap in a two-op sweep moves on to subtraction.
          if (a_last && b_last && both) op <= 1'b1;
        end
        DONE: pass <= err_count == '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_selftest_engine.sv
// tb_alu_selftest_engine: scoreboard bench driving three engines against behavioural ALUs with selectable faults
module tb_alu_selftest_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_i[3];
  logic [1:0] mode_i[3];
  int flt[3];
  logic done_i[3], busy_i[3], pass_i[3];
  int err_i[3], fv_i[3], fg_i[3], a_i[3], b_i[3];
  int checks = 0;
  int errors = 0;
  typedef struct {int err; int fvec; int fgot; int pass; int cyc;} exp_t;
  exp_t sb[$];

  function automatic int alu_f(int w, int s, int a, int b, int fault);
    int m, nb, sum, r, c, z, v, am, bm, rm;
    m = (1 << w) - 1;
    nb = (s != 0) ? (((1 << w) - b) & m) : b;
    sum = a + nb;
    r = sum & m;
    c = (sum >> w) & 1;
    z = int'(r == 0);
    am = (a >> (w - 1)) & 1;
    bm = (b >> (w - 1)) & 1;
    rm = (r >> (w - 1)) & 1;
    v = (s != 0) ? int'(am != bm && rm != am) : int'(am == bm && rm != am);
    case (fault)
      1: r = r & ~1;
      2: if (s != 0 && b == 0) c = 1;
      3: begin r = m; c = 0; z = 1; v = 0; end
      4: v = 0;
      6: if (s != 0) c = 0;
      default: ;
    endcase
    return (c << (w + 2)) | (z << (w + 1)) | (v << w) | r;
  endfunction

  function automatic exp_t model(int w, int md, int fault, int s);
    exp_t e;
    int vec, g, x, sat;
    e = '{0, 0, 0, 0, 0};
    vec = 0;
    sat = (1 << (2 * w + 1)) - 1;
    for (int o = 0; o < 2; o++) begin
      if ((md == 0 && o == 1) || (md == 1 && o == 0)) continue;
      for (int a = 0; a < (1 << w); a++)
        for (int b = 0; b < (1 << w); b++) begin
          g = alu_f(w, o, a, b, 0);
          x = alu_f(w, o, a, b, fault);
          vec++;
          if (g != x) begin
            if (e.err == 0) begin
              e.fvec = (o << (2 * w)) | (a << w) | b;
              e.fgot = x;
            end
            if (e.err < sat) e.err++;
          end
        end
    end
    e.cyc = vec * (s + 2) + 1;
    e.pass = int'(e.err == 0);
    return e;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // instance 0: WIDTH 4, SETTLE 1, combinational ALU
  logic s0, c0, z0, v0, d0, bz0, p0;
  logic [3:0] a0, b0, r0;
  logic [8:0] e0, fv0;
  logic [6:0] fg0, g0;
  always_comb g0 = 7'(alu_f(4, int'(s0), int'(a0), int'(b0), flt[0]));
  assign {c0, z0, v0, r0} = g0;
  alu_selftest_engine #(.WIDTH(4), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .mode(mode_i[0]),
    .alu_sub_add(s0), .alu_a(a0), .alu_b(b0), .alu_result(r0), .alu_carry(c0),
    .alu_zero(z0), .alu_overflow(v0), .busy(bz0), .done(d0), .pass(p0),
    .err_count(e0), .fail_vec(fv0), .fail_got(fg0));

  // instance 1: WIDTH 4, SETTLE 3, ALU with three register stages of latency
  logic s1, c1, z1, v1, d1, bz1, p1;
  logic [3:0] a1, b1, r1;
  logic [8:0] e1, fv1;
  logic [6:0] fg1, q1a, q1b, q1c;
  always_ff @(posedge clk) begin
    q1a <= 7'(alu_f(4, int'(s1), int'(a1), int'(b1), flt[1]));
    q1b <= q1a;
    q1c <= q1b;
  end
  assign {c1, z1, v1, r1} = q1c;
  alu_selftest_engine #(.WIDTH(4), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .mode(mode_i[1]),
    .alu_sub_add(s1), .alu_a(a1), .alu_b(b1), .alu_result(r1), .alu_carry(c1),
    .alu_zero(z1), .alu_overflow(v1), .busy(bz1), .done(d1), .pass(p1),
    .err_count(e1), .fail_vec(fv1), .fail_got(fg1));

  // instance 2: WIDTH 2, SETTLE 1
  logic s2, c2, z2, v2, d2, bz2, p2;
  logic [1:0] a2, b2, r2;
  logic [4:0] e2, fv2, fg2, g2;
  always_comb g2 = 5'(alu_f(2, int'(s2), int'(a2), int'(b2), flt[2]));
  assign {c2, z2, v2, r2} = g2;
  alu_selftest_engine #(.WIDTH(2), .SETTLE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .mode(mode_i[2]),
    .alu_sub_add(s2), .alu_a(a2), .alu_b(b2), .alu_result(r2), .alu_carry(c2),
    .alu_zero(z2), .alu_overflow(v2), .busy(bz2), .done(d2), .pass(p2),
    .err_count(e2), .fail_vec(fv2), .fail_got(fg2));

  always_comb begin
    done_i[0] = d0; busy_i[0] = bz0; pass_i[0] = p0;
    err_i[0] = int'(e0); fv_i[0] = int'(fv0); fg_i[0] = int'(fg0); a_i[0] = int'(a0); b_i[0] = int'(b0);
    done_i[1] = d1; busy_i[1] = bz1; pass_i[1] = p1;
    err_i[1] = int'(e1); fv_i[1] = int'(fv1); fg_i[1] = int'(fg1); a_i[1] = int'(a1); b_i[1] = int'(b1);
    done_i[2] = d2; busy_i[2] = bz2; pass_i[2] = p2;
    err_i[2] = int'(e2); fv_i[2] = int'(fv2); fg_i[2] = int'(fg2); a_i[2] = int'(a2); b_i[2] = int'(b2);
  end

  task automatic run_sweep(input int idx, input int w, input int s, input int md, input int fault, input int restart_at);
    exp_t e;
    int n, nb;
    bit seen;
    string t;
    t = $sformatf("u%0d m%0d f%0d", idx, md, fault);
    flt[idx] = fault;
    sb.push_back(model(w, md, fault, s));
    mode_i[idx] = 2'(md);
    start_i[idx] = 1'b1;
    n = 0;
    nb = 0;
    seen = 0;
    while (!seen && n < sb[0].cyc + 20) begin
      @(posedge clk);
      #1;
      n++;
      start_i[idx] = (n == restart_at);
      mode_i[idx] = (n == restart_at) ? 2'b00 : 2'(md);
      if (busy_i[idx]) nb++;
      if (done_i[idx]) seen = 1;
    end
    start_i[idx] = 1'b0;
    e = sb.pop_front();
    check({t, " done_seen"}, int'(seen), 1);
    check({t, " done_cycle"}, n, e.cyc);
    check({t, " busy_cycles"}, nb, e.cyc - 1);
    check({t, " err_count"}, err_i[idx], e.err);
    check({t, " fail_vec"}, fv_i[idx], e.fvec);
    check({t, " fail_got"}, fg_i[idx], e.fgot);
    @(posedge clk);
    #1;
    check({t, " pass"}, int'(pass_i[idx]), e.pass);
    check({t, " done_low"}, int'(done_i[idx]), 0);
    check({t, " busy_low"}, int'(busy_i[idx]), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      mode_i[i] = 2'b00;
      flt[i] = 0;
    end
    #12;
    check("rst busy", int'(busy_i[0]), 0);
    check("rst done", int'(done_i[0]), 0);
    check("rst pass", int'(pass_i[0]), 0);
    check("rst err", err_i[0], 0);
    check("rst fail_vec", fv_i[0], 0);
    check("rst fail_got", fg_i[0], 0);
    check("rst alu_a", a_i[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // clean ALU, both ops, with a second start ignored mid-sweep
    run_sweep(0, 4, 1, 2, 0, 50);
    run_sweep(0, 4, 1, 0, 1, 0);
    run_sweep(0, 4, 1, 1, 2, 0);
    // asynchronous reset at vector 100 of a failing sweep
    flt[0] = 1;
    mode_i[0] = 2'b00;
    start_i[0] = 1'b1;
    @(posedge clk);
    #1;
    start_i[0] = 1'b0;
    n = 0;
    while (!(a_i[0] == 6 && b_i[0] == 4) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_rst busy", int'(busy_i[0]), 1);
    check("pre_rst err_nonzero", int'(err_i[0] > 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst busy", int'(busy_i[0]), 0);
    check("async_rst err", err_i[0], 0);
    check("async_rst fail_vec", fv_i[0], 0);
    check("async_rst alu_a", a_i[0], 0);
    check("async_rst alu_b", b_i[0], 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst no_done", int'(done_i[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_sweep(0, 4, 1, 0, 1, 0);
    // three-cycle-latency ALU: correct only if operands are held through the settle window
    run_sweep(1, 4, 3, 2, 0, 0);
    run_sweep(1, 4, 3, 0, 4, 0);
    run_sweep(1, 4, 3, 1, 4, 0);
    run_sweep(1, 4, 3, 1, 6, 0);
    // narrow engine: reserved mode and saturation
    run_sweep(2, 2, 1, 3, 0, 0);
    run_sweep(2, 2, 1, 2, 3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
